dbus_axi_bridge: RTL and testbench
==================================

# dbus_axi_bridge

Responder end of the execute stage's data-bus handshake (`dcache_req`/`dcache_addr_ok`/`dcache_data_ok`), converting each accepted uncached load or store into one single-beat AXI4 transaction. It sits between the AGU's DBus port and the system AXI interconnect, and is used for uncached and MMIO space. It holds at most one transaction in flight.

## Interface
- `ID`, default 0: constant value driven on `arid`/`awid`; `rid`/`bid` are ignored.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-low reset.
- `dcache_req` in 1: request valid.
- `dcache_wr` in 1: 1 = store, 0 = load.
- `dcache_wstrb` in 4: store byte strobes.
- `dcache_size` in 3: access size; 0 = byte, 1 = half, 2 = word, >2 treated as word.
- `dcache_addr` in 32: physical address, passed through unaligned.
- `dcache_wdata` in 32: store data.
- `dcache_addr_ok` out 1: request accepted this cycle when `dcache_req` is also 1.
- `dcache_data_ok` out 1: one-cycle completion pulse.
- `dcache_rdata` out 32: load data, valid while `dcache_data_ok`=1.
- `bus_err` out 1: pulses with `dcache_data_ok` when the AXI response is not OKAY.
- Read address channel: `arid` 4, `araddr` 32, `arsize` 3, `arvalid` out; `arready` in. `arlen`=0 and `arburst`=1 are constant.
- Read data channel: `rdata` 32, `rresp` 2, `rvalid` in; `rready` out.
- Write address channel: `awid` 4, `awaddr` 32, `awsize` 3, `awvalid` out; `awready` in. `awlen`=0 and `awburst`=1 are constant.
- Write data channel: `wdata` 32, `wstrb` 4, `wvalid` out; `wready` in. `wlast` = `wvalid`.
- Write response channel: `bresp` 2, `bvalid` in; `bready` out.

## Operation
- FSM states: `IDLE`, `RD_AR`, `RD_R`, `WR_AWW`, `WR_B`, `DONE`.
- **`IDLE`**
  - `dcache_addr_ok`=1.
  - On `dcache_req`, capture addr, wdata, wstrb, size and wr into request registers.
  - Next state is `RD_AR` for a load, `WR_AWW` for a store.
- **`RD_AR`**
  - `arvalid`=1, `araddr` = captured addr, `arsize` = captured size (clamped to 2).
  - On `arvalid && arready`, go to `RD_R`.
- **`RD_R`**
  - `rready`=1.
  - On `rvalid`, capture `rdata` into `dcache_rdata` and latch `err = (rresp != 0)`, then go to `DONE`.
- **`WR_AWW`**
  - `awvalid` and `wvalid` are driven independently; each drops after its own handshake.
  - Track `aw_done` and `w_done`. Handshakes may occur in the same cycle or in either order.
  - When both are done (including a handshake in the current cycle), go to `WR_B`.
- **`WR_B`**
  - `bready`=1.
  - On `bvalid`, latch `err = (bresp != 0)` and go to `DONE`.
- **`DONE`**
  - `dcache_data_ok`=1 and `bus_err`=err for exactly one cycle.
  - `dcache_rdata` holds the captured value; it is don't-care for stores.
  - Next state is `IDLE`.
- `dcache_addr_ok`=0 in every state except `IDLE`. Requests presented in other states are not accepted and must be held by the requester.
- There is no flush input: every accepted transaction runs to completion and produces exactly one `dcache_data_ok`.
- Request registers are loaded only on accept, so input changes after the accept are ignored.

## Timing
- **Reset.** While `reset`=0, asynchronously:
  - state = `IDLE`;
  - all AXI valid/ready outputs, `dcache_data_ok` and `bus_err` = 0;
  - `dcache_rdata`, address, data and strobe registers = 0;
  - `aw_done` = `w_done` = 0.
- **Reset mid-transaction.** Abandon immediately and return to `IDLE`. The interconnect is reset in the same domain.
- **Minimum load latency** (accept in cycle 0, `arready` and `rvalid` both already high):
  - `arvalid` in cycle 1;
  - `rready` in cycle 2;
  - `dcache_data_ok` in cycle 3;
  - next accept in cycle 4.
- **Minimum store latency:** AW and W in cycle 1, B in cycle 2, `dcache_data_ok` in cycle 3.
- Each cycle `arready`, `rvalid`, `awready`, `wready` or `bvalid` stays low adds one cycle of latency.
- AXI valids, once asserted, stay asserted with stable payload until their handshake completes (AXI rule).
- All outputs are driven from registers or state decode. There is no combinational path from AXI inputs to `dcache_*` outputs.

## Test plan
- **Load, zero wait.** Load addr 0x1FC0_0000, size 2; slave gives `rdata`=0xDEAD_BEEF, `rresp`=0, `arready`=1 → `araddr`=0x1FC0_0000, `arsize`=2, `dcache_data_ok` 3 cycles after accept with `dcache_rdata`=0xDEAD_BEEF, `bus_err`=0.
- **Store, W before AW.** Store addr 0x1FAF_0004, wstrb 0x3, size 1, wdata 0x0000_1234; `wready` high, `awready` held low 3 cycles → `wvalid` drops after 1 cycle, `awvalid` held 4 cycles with stable payload, `bready` only after both handshakes, exactly one `dcache_data_ok`.
- **Back-to-back.** `dcache_req` held high with a load then a store → `dcache_addr_ok`=0 from the cycle after the first accept until the first `dcache_data_ok` has completed; the second request is accepted in the cycle after `DONE`.
- **Error response.** `bresp`=2'b10 on a store → `bus_err`=1 in the same cycle as `dcache_data_ok`, then 0.
- **Reset mid-transaction.** Assert `reset`=0 while in `RD_R` → `rready`, `dcache_data_ok` and `arvalid` read 0 immediately; after release `dcache_addr_ok`=1 and a new load completes normally.
- **Size clamp and byte load.** Load with `dcache_size`=3'b111 → `arsize`=2; a byte load at 0x1FAF_0003 → `arsize`=0 and `araddr`=0x1FAF_0003 unaligned, passed through.

Source files
------------

// File: rtl/dbus_axi_bridge.sv
//------------------------------------------------------------------------------
// Module      : dbus_axi_bridge
// Description : Data-bus handshake responder that turns each accepted
//               uncached load/store into one single-beat AXI4 transaction.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dbus_axi_bridge #(
    parameter logic [3:0] ID = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    // data-bus side
    input  logic        dcache_req,
    input  logic        dcache_wr,
    input  logic [3:0]  dcache_wstrb,
    input  logic [2:0]  dcache_size,
    input  logic [31:0] dcache_addr,
    input  logic [31:0] dcache_wdata,
    output logic        dcache_addr_ok,
    output logic        dcache_data_ok,
    output logic [31:0] dcache_rdata,
    output logic        bus_err,
    // read address channel
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    // read data channel
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    // write address channel
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awvalid,
    input  logic        awready,
    // write data channel
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    // write response channel
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_rd_ar  = 3'd1;
    localparam logic [2:0] c_st_rd_r   = 3'd2;
    localparam logic [2:0] c_st_wr_aww = 3'd3;
    localparam logic [2:0] c_st_wr_b   = 3'd4;
    localparam logic [2:0] c_st_done   = 3'd5;

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [2:0]  r_size;
    logic        r_wr;
    logic        r_aw_done;
    logic        r_w_done;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [2:0]  w_size_clamped;
    logic        w_aw_hs;
    logic        w_w_hs;

    // Sizes above a word are not supported by a 32-bit bus; issue a word.
    assign w_size_clamped = (r_size > 3'd2) ? 3'd2 : r_size;

    assign dcache_addr_ok = (r_state == c_st_idle);
    assign dcache_data_ok = (r_state == c_st_done);
    assign bus_err        = (r_state == c_st_done) & r_err;
    assign dcache_rdata   = r_rdata;

    assign arid    = ID;
    assign araddr  = r_addr;
    assign arlen   = 8'd0;
    assign arsize  = w_size_clamped;
    assign arburst = 2'b01;
    assign arvalid = (r_state == c_st_rd_ar);
    assign rready  = (r_state == c_st_rd_r);

    assign awid    = ID;
    assign awaddr  = r_addr;
    assign awlen   = 8'd0;
    assign awsize  = w_size_clamped;
    assign awburst = 2'b01;
    assign awvalid = (r_state == c_st_wr_aww) & ~r_aw_done;
    assign wdata   = r_wdata;
    assign wstrb   = r_wstrb;
    assign wvalid  = (r_state == c_st_wr_aww) & ~r_w_done;
    assign wlast   = wvalid;
    assign bready  = (r_state == c_st_wr_b);

    assign w_aw_hs = awvalid & awready;
    assign w_w_hs  = wvalid & wready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (dcache_req) begin
                    w_next = dcache_wr ? c_st_wr_aww : c_st_rd_ar;
                end
            end
            c_st_rd_ar: begin
                if (arready) begin
                    w_next = c_st_rd_r;
                end
            end
            c_st_rd_r: begin
                if (rvalid) begin
                    w_next = c_st_done;
                end
            end
            c_st_wr_aww: begin
                // Either channel may finish first; a same-cycle handshake counts.
                if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
                    w_next = c_st_wr_b;
                end
            end
            c_st_wr_b: begin
                if (bvalid) begin
                    w_next = c_st_done;
                end
            end
            c_st_done: begin
                w_next = c_st_idle;
            end
            default: begin
                w_next = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= c_st_idle;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_wstrb   <= 4'd0;
            r_size    <= 3'd0;
            r_wr      <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_rdata   <= 32'd0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                c_st_idle: begin
                    if (dcache_req) begin
                        r_addr    <= dcache_addr;
                        r_wdata   <= dcache_wdata;
                        r_wstrb   <= dcache_wstrb;
                        r_size    <= dcache_size;
                        r_wr      <= dcache_wr;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                    end
                end
                c_st_rd_r: begin
                    if (rvalid) begin
                        r_rdata <= rdata;
                        r_err   <= (rresp != 2'b00);
                    end
                end
                c_st_wr_aww: begin
                    if (w_aw_hs) begin
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_w_done <= 1'b1;
                    end
                end
                c_st_wr_b: begin
                    if (bvalid) begin
                        r_err <= (bresp != 2'b00);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Captured direction is kept for debug visibility only.
    logic w_unused;
    assign w_unused = r_wr;

endmodule

`default_nettype wire

// File: tb/tb_dbus_axi_bridge.sv
//------------------------------------------------------------------------------
// Module      : tb_dbus_axi_bridge
// Description : Directed self-checking bench for dbus_axi_bridge.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dbus_axi_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        dcache_req;
    logic        dcache_wr;
    logic [3:0]  dcache_wstrb;
    logic [2:0]  dcache_size;
    logic [31:0] dcache_addr;
    logic [31:0] dcache_wdata;
    logic        dcache_addr_ok;
    logic        dcache_data_ok;
    logic [31:0] dcache_rdata;
    logic        bus_err;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int n_checks = 0;
    int n_errors = 0;

    dbus_axi_bridge #(.ID(4'd5)) u_dut (
        .clk(clk), .reset(reset),
        .dcache_req(dcache_req), .dcache_wr(dcache_wr),
        .dcache_wstrb(dcache_wstrb), .dcache_size(dcache_size),
        .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata),
        .dcache_addr_ok(dcache_addr_ok), .dcache_data_ok(dcache_data_ok),
        .dcache_rdata(dcache_rdata), .bus_err(bus_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Zero-wait load: accept in cycle 0, data_ok in cycle 3, ready again in cycle 4.
    task automatic do_load(input logic [31:0] addr, input logic [2:0] size,
                           input logic [31:0] data, input logic [2:0] exp_size);
        dcache_req = 1'b1; dcache_wr = 1'b0; dcache_addr = addr; dcache_size = size;
        arready = 1'b1; rvalid = 1'b1; rdata = data; rresp = 2'b00;
        check("ld_c0_addr_ok", {31'd0, dcache_addr_ok}, 32'd1);
        step();
        dcache_req = 1'b0; dcache_addr = 32'hFFFF_FFFF; dcache_size = 3'd0;
        check("ld_c1_arvalid", {31'd0, arvalid}, 32'd1);
        check("ld_c1_araddr", araddr, addr);
        check("ld_c1_arsize", {29'd0, arsize}, {29'd0, exp_size});
        check("ld_c1_addr_ok", {31'd0, dcache_addr_ok}, 32'd0);
        step();
        check("ld_c2_rready", {31'd0, rready}, 32'd1);
        check("ld_c2_arvalid", {31'd0, arvalid}, 32'd0);
        step();
        check("ld_c3_data_ok", {31'd0, dcache_data_ok}, 32'd1);
        check("ld_c3_rdata", dcache_rdata, data);
        check("ld_c3_bus_err", {31'd0, bus_err}, 32'd0);
        rvalid = 1'b0;
        step();
        check("ld_c4_data_ok", {31'd0, dcache_data_ok}, 32'd0);
        check("ld_c4_addr_ok", {31'd0, dcache_addr_ok}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        dcache_req = 1'b0; dcache_wr = 1'b0; dcache_wstrb = 4'h0; dcache_size = 3'd0;
        dcache_addr = 32'd0; dcache_wdata = 32'd0;
        arready = 1'b0; rdata = 32'd0; rresp = 2'b00; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
        step();
        step();
        check("rst_addr_ok", {31'd0, dcache_addr_ok}, 32'd1);
        check("rst_arvalid", {31'd0, arvalid}, 32'd0);
        check("rst_awvalid", {31'd0, awvalid}, 32'd0);
        check("rst_wvalid", {31'd0, wvalid}, 32'd0);
        check("rst_data_ok", {31'd0, dcache_data_ok}, 32'd0);
        check("rst_rdata", dcache_rdata, 32'd0);
        check("rst_awaddr", awaddr, 32'd0);
        reset = 1'b1;
        step();

        // Load, zero wait; constant channel fields
        do_load(32'h1FC0_0000, 3'd2, 32'hDEAD_BEEF, 3'd2);
        check("arid", {28'd0, arid}, 32'd5);
        check("awid", {28'd0, awid}, 32'd5);
        check("arlen", {24'd0, arlen}, 32'd0);
        check("arburst", {30'd0, arburst}, 32'd1);
        check("awburst", {30'd0, awburst}, 32'd1);

        // Store, W before AW (awready low 3 cycles)
        dcache_req = 1'b1; dcache_wr = 1'b1; dcache_addr = 32'h1FAF_0004;
        dcache_wstrb = 4'h3; dcache_size = 3'd1; dcache_wdata = 32'h0000_1234;
        awready = 1'b0; wready = 1'b1; bvalid = 1'b0; bresp = 2'b00;
        step();
        dcache_req = 1'b0; dcache_wdata = 32'hBAD0_BAD0; dcache_wstrb = 4'hF;
        check("st_c1_awvalid", {31'd0, awvalid}, 32'd1);
        check("st_c1_wvalid", {31'd0, wvalid}, 32'd1);
        check("st_c1_wlast", {31'd0, wlast}, 32'd1);
        check("st_c1_awaddr", awaddr, 32'h1FAF_0004);
        check("st_c1_awsize", {29'd0, awsize}, 32'd1);
        check("st_c1_wstrb", {28'd0, wstrb}, 32'h3);
        check("st_c1_wdata", wdata, 32'h0000_1234);
        step();
        check("st_c2_wvalid", {31'd0, wvalid}, 32'd0);
        check("st_c2_awvalid", {31'd0, awvalid}, 32'd1);
        check("st_c2_bready", {31'd0, bready}, 32'd0);
        step();
        check("st_c3_awvalid", {31'd0, awvalid}, 32'd1);
        check("st_c3_awaddr", awaddr, 32'h1FAF_0004);
        step();
        awready = 1'b1;
        check("st_c4_awvalid", {31'd0, awvalid}, 32'd1);
        check("st_c4_bready", {31'd0, bready}, 32'd0);
        check("st_c4_data_ok", {31'd0, dcache_data_ok}, 32'd0);
        step();
        check("st_c5_awvalid", {31'd0, awvalid}, 32'd0);
        check("st_c5_bready", {31'd0, bready}, 32'd1);
        bvalid = 1'b1;
        step();
        bvalid = 1'b0;
        check("st_c6_data_ok", {31'd0, dcache_data_ok}, 32'd1);
        check("st_c6_bus_err", {31'd0, bus_err}, 32'd0);
        step();
        check("st_c7_data_ok", {31'd0, dcache_data_ok}, 32'd0);
        awready = 1'b0; wready = 1'b0;

        // Back-to-back: load then store with req held high
        dcache_req = 1'b1; dcache_wr = 1'b0; dcache_addr = 32'h1FC0_0010; dcache_size = 3'd2;
        arready = 1'b1; rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'b00;
        step();
        dcache_wr = 1'b1; dcache_addr = 32'h1FAF_0020; dcache_wdata = 32'hA5A5_5A5A;
        dcache_wstrb = 4'hF; dcache_size = 3'd2;
        check("b2b_c1_addr_ok", {31'd0, dcache_addr_ok}, 32'd0);
        check("b2b_c1_araddr", araddr, 32'h1FC0_0010);
        step();
        check("b2b_c2_addr_ok", {31'd0, dcache_addr_ok}, 32'd0);
        step();
        check("b2b_c3_addr_ok", {31'd0, dcache_addr_ok}, 32'd0);
        check("b2b_c3_data_ok", {31'd0, dcache_data_ok}, 32'd1);
        check("b2b_c3_rdata", dcache_rdata, 32'h1234_5678);
        rvalid = 1'b0;
        step();
        check("b2b_c4_addr_ok", {31'd0, dcache_addr_ok}, 32'd1);
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
        step();
        dcache_req = 1'b0; dcache_addr = 32'h0BAD_0000;
        check("b2b_c5_awvalid", {31'd0, awvalid}, 32'd1);
        check("b2b_c5_awaddr", awaddr, 32'h1FAF_0020);
        check("b2b_c5_wdata", wdata, 32'hA5A5_5A5A);
        step();
        check("b2b_c6_bready", {31'd0, bready}, 32'd1);
        step();
        check("b2b_c7_data_ok", {31'd0, dcache_data_ok}, 32'd1);
        step();
        check("b2b_c8_addr_ok", {31'd0, dcache_addr_ok}, 32'd1);

        // Error response on a store
        dcache_req = 1'b1; dcache_wr = 1'b1; dcache_addr = 32'h1FAF_0030; dcache_size = 3'd2;
        bresp = 2'b10;
        step();
        dcache_req = 1'b0;
        step();
        step();
        check("err_c3_data_ok", {31'd0, dcache_data_ok}, 32'd1);
        check("err_c3_bus_err", {31'd0, bus_err}, 32'd1);
        bvalid = 1'b0; bresp = 2'b00; awready = 1'b0; wready = 1'b0;
        step();
        check("err_c4_bus_err", {31'd0, bus_err}, 32'd0);

        // Reset while waiting in RD_R
        dcache_req = 1'b1; dcache_wr = 1'b0; dcache_addr = 32'h1FC0_0040; dcache_size = 3'd2;
        arready = 1'b1; rvalid = 1'b0; rdata = 32'h5555_AAAA;
        step();
        dcache_req = 1'b0;
        step();
        check("mid_rready_before", {31'd0, rready}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rready", {31'd0, rready}, 32'd0);
        check("mid_arvalid", {31'd0, arvalid}, 32'd0);
        check("mid_data_ok", {31'd0, dcache_data_ok}, 32'd0);
        step();
        reset = 1'b1;
        check("mid_addr_ok", {31'd0, dcache_addr_ok}, 32'd1);
        check("mid_rdata", dcache_rdata, 32'd0);
        do_load(32'h1FC0_0044, 3'd2, 32'hCAFE_F00D, 3'd2);

        // Size clamp and unaligned byte load
        do_load(32'h1FAF_0008, 3'b111, 32'h0BAD_CAFE, 3'd2);
        do_load(32'h1FAF_0003, 3'd0, 32'h0000_0077, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
